// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles the signals between two requesters, the arbiter, and the shared
// ALU datapath.
//   req0_*/req1_* : valid/ready handshake, operands a/b (N bits), 4-bit op code
//   alu_a/alu_b/alu_op : operands and op select driven to the shared datapath
//   alu_result/alu_flags : combinational result and flags from the datapath
//   rsp_* : registered response (strobe, owner id, result, flags, illegal-op error)
// Modports:
//   slave  - the arbiter side
//   master - the requester/datapath side (the environment around the arbiter)
interface alu_arbiter_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [3:0]   req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [3:0]   req1_op;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_op;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;

    logic         rsp_valid;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_flags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_flags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter that lets two requesters share one combinational ALU.
// A request is accepted in IDLE, its operands are presented to the datapath
// during EXEC, and the registered result is strobed out during RESP.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - alu_arbiter_if slave modport (request handshakes, datapath, response)
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic clk,
    input  logic rst,
    alu_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] MAX_OP = 4'd10;

    logic [1:0]   state;
    logic         last_grant;
    logic         grant;
    logic         hs0;
    logic         hs1;

    logic [N-1:0] lat_a;
    logic [N-1:0] lat_b;
    logic [3:0]   lat_op;
    logic         lat_id;

    logic [N-1:0] res_q;
    logic [3:0]   flags_q;
    logic         err_q;
    logic         id_q;

    // With both requesters valid the one that was not served last wins;
    // otherwise the grant simply follows whichever one is valid.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = bus.req1_valid;
        end
    end

    // Ready is combinational so the handshake lands in the same IDLE cycle;
    // it is masked by rst so nothing is accepted while reset is held.
    assign hs0 = !rst && (state == IDLE) && bus.req0_valid && !grant;
    assign hs1 = !rst && (state == IDLE) && bus.req1_valid &&  grant;

    assign bus.req0_ready = hs0;
    assign bus.req1_ready = hs1;

    assign bus.alu_a  = lat_a;
    assign bus.alu_b  = lat_b;
    assign bus.alu_op = lat_op;

    assign bus.rsp_valid  = (state == RESP) && !rst;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.rsp_err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            lat_id     <= 1'b0;
            res_q      <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
            id_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs0 || hs1) begin
                        state      <= EXEC;
                        last_grant <= hs1;
                        lat_id     <= hs1;
                        lat_a      <= hs1 ? bus.req1_a  : bus.req0_a;
                        lat_b      <= hs1 ? bus.req1_b  : bus.req0_b;
                        lat_op     <= hs1 ? bus.req1_op : bus.req0_op;
                    end
                end
                EXEC: begin
                    // Illegal op codes never let datapath output leak into the response.
                    state <= RESP;
                    id_q  <= lat_id;
                    if (lat_op > MAX_OP) begin
                        res_q   <= '0;
                        flags_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        res_q   <= bus.alu_result;
                        flags_q <= bus.alu_flags;
                        err_q   <= 1'b0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
